// File: rtl/feature_writer.sv
// Streams one frame from a frame memory into a feature FIFO in row-major order.
// Reads are throttled so in-flight reads plus the 2-entry skid buffer never exceed two pixels.
module feature_writer #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_eol,
    output logic              busy,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                   state_q;
    logic                     busy_q, done_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [CW-1:0]            col_q;
    logic [RW-1:0]            row_q;
    logic                     pend_q, pend_eol_q;
    logic [1:0][DATA_W-1:0]   buf_data_q;
    logic [1:0]               buf_eol_q;
    logic                     rptr_q, wptr_q;
    logic [1:0]               cnt_q;

    logic       issue, last_pix, final_acc;
    logic [2:0] load;

    assign wr_en   = (cnt_q != 2'd0) && !fifo_full;
    assign wr_data = buf_data_q[rptr_q];
    assign wr_eol  = buf_eol_q[rptr_q];

    // Pixels committed after this edge if no new read is issued; wr_en implies cnt_q >= 1.
    assign load      = {2'b00, pend_q} + {1'b0, cnt_q} - {2'b00, wr_en};
    assign issue     = (state_q == STREAM) && (load < 3'd2);
    assign last_pix  = (col_q == COL_LAST) && (row_q == ROW_LAST);
    assign final_acc = wr_en && (cnt_q == 2'd1) && !pend_q;

    assign mem_rd_en  = issue;
    assign mem_addr   = addr_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    state_q <= STREAM;
                    busy_q  <= 1'b1;
                end
                STREAM: if (issue && last_pix) state_q <= DRAIN;
                DRAIN: if (final_acc) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pend_q     <= 1'b0;
            pend_eol_q <= 1'b0;
        end else begin
            pend_q     <= issue;
            pend_eol_q <= issue && (col_q == COL_LAST);
            if (state_q == IDLE && start) begin
                addr_q <= '0;
                col_q  <= '0;
                row_q  <= '0;
            end else if (issue && !last_pix) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    // Skid buffer: read data lands one cycle after its strobe; head is held while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_q <= '0;
            buf_eol_q  <= '0;
            rptr_q     <= 1'b0;
            wptr_q     <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            if (pend_q) begin
                buf_data_q[wptr_q] <= mem_rd_data;
                buf_eol_q[wptr_q]  <= pend_eol_q;
                wptr_q             <= ~wptr_q;
            end
            if (wr_en) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, pend_q} - {1'b0, wr_en};
        end
    end

endmodule

// File: tb/tb_feature_writer.sv
// Table-driven frame scenarios for feature_writer with a behavioural frame memory (data = addr[7:0]).
module tb_feature_writer;
    localparam int W = 32, H = 32, DW = 8, AW = 10, NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          fifo_full = 1'b0;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_en, wr_en, wr_eol, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;

    feature_writer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data), .wr_eol(wr_eol),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem_addr[7:0];
    end

    typedef struct {
        int mode;          // 0 none, 1 random, 2 toggle, 3 stall cycles 2..21
        int chain;         // start in the first IDLE cycle after previous frame
        int xstart;        // extra start pulse cycle, -1 none
        int start_in_done; // pulse start during expected DONE cycle
        int rst_at;        // assert reset after this many writes, -1 none
        int exp_first;     // -1 = timing not checked
        int exp_last;
        int exp_done;
        int exp_blow;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ffval(input int mode, input int c);
        case (mode)
            1:       return 1'($urandom_range(0, 1));
            2:       return (c % 2) == 1;
            3:       return (c >= 2) && (c < 22);
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_frame(input vec_t v, input int idx);
        int c = 0, nwr = 0, nrd = 0, first = -1, last = -1, done_c = -1, dn_cnt = 0;
        int ord_bad = 0, eol_bad = 0, eol_cnt = 0, fviol = 0, maxo = 0;
        int stall_bad = 0, stall_rd = -1, idle_bad = 0, to = 0, aborted = 0;
        if (v.chain == 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                start = 1'b0; fifo_full = 1'b0;
                @(negedge clk);
                if (busy || wr_en || mem_rd_en || frame_done) idle_bad++;
            end
            check($sformatf("v%0d idle", idx), idle_bad, 0);
            @(posedge clk); #1;
        end
        forever begin
            start = (c == 0) || (c == v.xstart) || (v.start_in_done != 0 && c == v.exp_done);
            fifo_full = ffval(v.mode, c);
            if (!(v.chain != 0 && c == 0)) begin
                @(negedge clk);
                if (wr_en) begin
                    if (fifo_full) fviol++;
                    if (int'(wr_data) != (nwr % 256)) ord_bad++;
                    if (wr_eol != ((nwr % W) == W - 1)) eol_bad++;
                    if (wr_eol) eol_cnt++;
                    if (nwr == 0) first = c;
                    last = c;
                    nwr++;
                end
                if (mem_rd_en) begin
                    if (int'(mem_addr) != nrd) ord_bad++;
                    nrd++;
                end
                if (nrd - nwr > maxo) maxo = nrd - nwr;
                if (v.mode == 3 && c >= 3 && c < 22 && (wr_en || wr_data != 0)) stall_bad++;
                if (v.mode == 3 && c == 21) stall_rd = nrd;
                if (frame_done) begin dn_cnt++; done_c = c; end
                if (v.rst_at >= 0 && nwr == v.rst_at) begin aborted = 1; break; end
                if (dn_cnt > 0 && !busy) break;
                if (c >= 4000) begin to = 1; break; end
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        if (aborted != 0) begin
            rst = 1'b0;
            fifo_full = 1'b0;
            #1;
            check($sformatf("v%0d rst ctrl", idx),
                  int'({busy, wr_en, mem_rd_en, frame_done, wr_eol}), 0);
            check($sformatf("v%0d rst addr", idx), int'(mem_addr), 0);
            check($sformatf("v%0d rst data", idx), int'(wr_data), 0);
            @(posedge clk); @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            check($sformatf("v%0d timeout", idx), to, 0);
            check($sformatf("v%0d writes", idx), nwr, NPIX);
            check($sformatf("v%0d reads", idx), nrd, NPIX);
            check($sformatf("v%0d order", idx), ord_bad, 0);
            check($sformatf("v%0d eol", idx), eol_bad, 0);
            check($sformatf("v%0d eol count", idx), eol_cnt, H);
            check($sformatf("v%0d wr while full", idx), fviol, 0);
            check($sformatf("v%0d occupancy<=2", idx), int'(maxo <= 2), 1);
            check($sformatf("v%0d done pulses", idx), dn_cnt, 1);
            if (v.exp_first >= 0) begin
                check($sformatf("v%0d first wr", idx), first, v.exp_first);
                check($sformatf("v%0d last wr", idx), last, v.exp_last);
                check($sformatf("v%0d done cyc", idx), done_c, v.exp_done);
                check($sformatf("v%0d busy low", idx), c, v.exp_blow);
            end
            if (v.mode == 3) begin
                check($sformatf("v%0d stall hold", idx), stall_bad, 0);
                check($sformatf("v%0d stall reads", idx), stall_rd, 2);
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 0, -1, 0, -1,  3, 1026, 1027, 1028};
        tbl[1] = '{0, 1, -1, 0, -1,  3, 1026, 1027, 1028};
        tbl[2] = '{1, 0, -1, 0, -1, -1,   -1,   -1,   -1};
        tbl[3] = '{2, 0, -1, 0, -1, -1,   -1,   -1,   -1};
        tbl[4] = '{3, 0, -1, 0, -1, 22, 1045, 1046, 1047};
        tbl[5] = '{0, 0,  5, 1, -1,  3, 1026, 1027, 1028};
        tbl[6] = '{0, 0, -1, 0, 500, -1,  -1,   -1,   -1};
        tbl[7] = '{0, 0, -1, 0, -1,  3, 1026, 1027, 1028};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", int'({busy, wr_en, mem_rd_en, frame_done, wr_eol}), 0);
        check("reset addr", int'(mem_addr), 0);
        check("reset data", int'(wr_data), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(tbl[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/feature_writer.md
FEATURE_WRITER -- requirements
Module: feature_writer

Interface
REQ-001 Parameter IMG_W, default 32, pixels per row.
REQ-002 Parameter IMG_H, default 32, rows per frame.
REQ-003 Parameter DATA_W, default 8, pixel width.
REQ-004 Parameter ADDR_W, default 10, memory address width; IMG_W*IMG_H SHALL fit in ADDR_W bits.
REQ-005 clk  in  1  single clock; all logic SHALL be rising-edge on clk.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 start  in  1  one-cycle request to stream one frame.
REQ-008 mem_rd_en  out  1  read strobe to frame memory.
REQ-009 mem_addr  out  ADDR_W  read address, row-major, 0 .. IMG_W*IMG_H-1.
REQ-010 mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
REQ-011 fifo_full  in  1  write side of the feature FWFT FIFO cannot accept.
REQ-012 wr_en  out  1  pixel write strobe into the feature FIFO.
REQ-013 wr_data  out  DATA_W  pixel written when wr_en=1.
REQ-014 wr_eol  out  1  qualifies wr_en: pixel is last of its row.
REQ-015 busy  out  1  frame in progress.
REQ-016 frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.

Function
REQ-017 The block SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-018 IDLE -> STREAM on start=1; busy SHALL be 1 in STREAM, DRAIN and DONE.
REQ-019 start while busy=1 SHALL be ignored (no queuing, no restart).
REQ-020 In STREAM, address counter SHALL start at 0 and increment by 1 per issued read; row/column counters SHALL track the issued pixel.
REQ-021 Returned data SHALL land in a 2-entry skid buffer; a read SHALL issue only when (reads in flight + buffer occupancy - write accepted this cycle) < 2.
REQ-022 wr_en SHALL equal (buffer non-empty AND NOT fifo_full), combinationally; wr_data/wr_eol SHALL come from the buffer head.
REQ-023 wr_en SHALL never be 1 while fifo_full=1; while stalled, head pixel and wr_eol SHALL be held unchanged.
REQ-024 Pixels SHALL be written in strict row-major order with no loss or duplication across any fifo_full pattern.
REQ-025 wr_eol SHALL be 1 exactly for column IMG_W-1 of each row.
REQ-026 After the read for address IMG_W*IMG_H-1 issues, STREAM -> DRAIN; no further mem_rd_en in that frame.
REQ-027 DRAIN -> DONE on the cycle the final pixel write is accepted; DONE SHALL last one cycle with frame_done=1, then -> IDLE with busy=0.
REQ-028 Unstalled throughput SHALL be one pixel per cycle: start at cycle 0 -> mem_rd_en cycle 1 (addr 0) -> first wr_en cycle 3; last wr_en at cycle IMG_W*IMG_H+2; frame_done at cycle IMG_W*IMG_H+3.
REQ-029 start asserted in the DONE cycle SHALL be ignored; start in the first IDLE cycle after DONE SHALL begin a new frame from address 0.
REQ-030 fifo_full toggling every cycle SHALL not violate REQ-021 occupancy bound nor REQ-024 ordering.

Reset
REQ-031 On rst=0: state=IDLE, counters=0, buffer emptied, in-flight reads discarded; mem_rd_en, wr_en, wr_eol, busy, frame_done=0, mem_addr=0, wr_data=0.
REQ-032 Reset asserted mid-frame SHALL abort immediately; no wr_en until a fresh start after reset release.
REQ-033 Memory data returning in the cycle after reset release SHALL be ignored.

Verification
REQ-034 Memory holds addr[7:0]; start, fifo_full=0 -> 1024 writes values 0..255 repeating, wr_en cycles 3..1026, frame_done at cycle 1027, busy low at 1028.
REQ-035 Same memory, fifo_full random 50% -> exactly 1024 writes in order, wr_en never high with fifo_full high, mem_rd_en count = 1024.
REQ-036 fifo_full=1 held 20 cycles from cycle 2 -> at most 2 reads issued, wr_en=0, wr_data held at 0; release -> stream resumes from pixel 0 without gap.
REQ-037 Check wr_eol -> high on writes 31, 63, ..., 1023 only (32 pulses).
REQ-038 Assert rst=0 at write 500, release, then start -> next frame begins at addr 0, first write value 0, no residual pixel written.
REQ-039 start pulsed at cycle 5 and in DONE cycle -> ignored; single frame, single frame_done.
